// File: rtl/if_pkg.sv
// if_pkg: shared types and defaults for the IF stage and its prefetch buffer.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package if_pkg;

    localparam int              DEF_XLEN     = 32;
    localparam logic [31:0]     DEF_RESET_PC = 32'h0000_0000;

`ifdef IF_MISALIGN_CHK_EN
    typedef enum logic [1:0] {BOOT, RUN, TRAP} fetch_state_t;
`else
    typedef enum logic [1:0] {BOOT, RUN} fetch_state_t;
`endif

    // One prefetched instruction together with the address it was fetched from.
    typedef struct packed {
        logic [DEF_XLEN-1:0] instr;
        logic [DEF_XLEN-1:0] pc;
    } if_entry_t;

    function automatic logic is_aligned(input logic [1:0] lsb);
        return (lsb == 2'b00);
    endfunction

endpackage

// File: rtl/if_fifo.sv
// if_fifo: synchronous FIFO of if_entry_t with push, pop, flush and occupancy count.
// Latency: a push is visible at head the cycle after it is written; head is read combinationally.
// Backpressure: none internally; push is ignored when full unless a pop frees a slot the same cycle.
module if_fifo
    import if_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  if_entry_t              push_data,
    input  logic                   pop,
    output if_entry_t              head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);

    if_entry_t      mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           full;
    logic           do_push;
    logic           do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; flush empties the queue in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Entry storage; no reset needed because head is only consumed while count is non-zero.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: holds the fetch PC, issues pipelined imem requests, buffers words and feeds ID.
// Latency: imem response to if_valid one cycle; redirect to first if_valid >= 3 cycles (1-cycle imem).
// Backpressure: id_ready low fills the prefetch FIFO; imem_req drops once FIFO+in-flight reach FIFO_DEPTH.
// Optional feature macro IF_MISALIGN_CHK_EN: misaligned redirect traps and raises fetch_misaligned.
module instr_fetch_unit
    import if_pkg::*;
#(
    parameter int              XLEN       = DEF_XLEN,
    parameter logic [XLEN-1:0] RESET_PC   = DEF_RESET_PC,
    parameter int              FIFO_DEPTH = 4,
    parameter int              MAX_OUTST  = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            if_valid,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_pc_plus4,
    input  logic            id_ready
`ifdef IF_MISALIGN_CHK_EN
    ,
    output logic            fetch_misaligned
`endif
);

    localparam int              CW      = $clog2(FIFO_DEPTH) + 1;
    localparam int              OW      = $clog2(MAX_OUTST + 1);
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q;
    logic [XLEN-1:0] rsp_pc_q;
    logic [XLEN-1:0] target_pc;
    logic [XLEN-1:0] req_addr;
    logic [OW-1:0]   outst_q, outst_d;
    logic [OW-1:0]   discard_q;
    logic [CW-1:0]   fifo_count;
    logic [CW:0]     occupancy;
    logic            fifo_empty;
    logic            has_room;
    logic            req;
    logic            gnt_acc;
    logic            push;
    logic            pop;
    if_entry_t       push_entry;
    if_entry_t       head_entry;

`ifdef IF_MISALIGN_CHK_EN
    logic            misaligned_q;
    assign target_pc = redirect_pc;
    assign req_addr  = fetch_pc_q;
`else
    // Without the trap there is nowhere to report a misaligned target, so the low bits are dropped.
    assign target_pc = redirect_pc & ~XLEN'(3);
    assign req_addr  = fetch_pc_q & ~XLEN'(3);
`endif

    // Entries already buffered plus words still in flight must never exceed the FIFO capacity.
    assign occupancy = (CW+1)'(fifo_count) + (CW+1)'(outst_q);
    assign has_room  = (occupancy < (CW+1)'(FIFO_DEPTH)) && (outst_q < OW'(MAX_OUTST));

    assign gnt_acc = req && imem_gnt;
    assign outst_d = outst_q + OW'(gnt_acc) - OW'(imem_rvalid);
    // Words requested before a redirect are dropped; so is any word arriving in the redirect cycle.
    assign push    = imem_rvalid && (discard_q == '0) && !redirect_valid;
    assign pop     = !fifo_empty && id_ready;

    assign push_entry.instr = imem_rdata;
    assign push_entry.pc    = rsp_pc_q;

    // Next state and request generation.
    always_comb begin
        state_d = state_q;
        req     = 1'b0;
        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     req = has_room;
`ifdef IF_MISALIGN_CHK_EN
            TRAP:    req = 1'b0;
`endif
            default: state_d = BOOT;
        endcase
`ifdef IF_MISALIGN_CHK_EN
        if (redirect_valid) state_d = is_aligned(redirect_pc[1:0]) ? RUN : TRAP;
`endif
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= BOOT;
        else        state_q <= state_d;
    end

    // Fetch PC, response PC, in-flight and discard counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            outst_q    <= '0;
            discard_q  <= '0;
        end else begin
            outst_q <= outst_d;
            if (redirect_valid) begin
                fetch_pc_q <= target_pc;
                rsp_pc_q   <= target_pc;
                discard_q  <= outst_d;
            end else begin
                if (gnt_acc) fetch_pc_q <= fetch_pc_q + PC_STEP;
                if (push)    rsp_pc_q   <= rsp_pc_q + PC_STEP;
                if (imem_rvalid && (discard_q != '0)) discard_q <= discard_q - OW'(1);
            end
        end
    end

`ifdef IF_MISALIGN_CHK_EN
    // Sticky misalignment flag, updated by every redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              misaligned_q <= 1'b0;
        else if (redirect_valid) misaligned_q <= !is_aligned(redirect_pc[1:0]);
    end
    assign fetch_misaligned = misaligned_q;
`endif

    if_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head_entry),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    assign imem_req    = req;
    assign imem_addr   = req ? req_addr : '0;
    assign if_valid    = !fifo_empty;
    assign if_instr    = if_valid ? head_entry.instr : '0;
    assign if_pc       = if_valid ? head_entry.pc : '0;
    assign if_pc_plus4 = if_valid ? (head_entry.pc + PC_STEP) : '0;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed checks of fetch ordering, backpressure, grant stalls and redirects.
// Latency: memory model returns each granted word a programmable number of cycles after grant.
// Backpressure: id_ready and grant enable are driven per test from the stimulus sequence.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata  = 32'h0;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic        id_ready;
`ifdef IF_MISALIGN_CHK_EN
    logic        fetch_misaligned;
`endif

    logic        gnt_en;
    int          lat;
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] mq_addr[$];
    int          mq_due[$];
    logic [31:0] acc_pc[$];
    logic [31:0] acc_instr[$];

    instr_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_pc_plus4    (if_pc_plus4),
        .id_ready       (id_ready)
`ifdef IF_MISALIGN_CHK_EN
        ,
        .fetch_misaligned (fetch_misaligned)
`endif
    );

    always #5 clk = ~clk;

    assign imem_gnt = imem_req && gnt_en;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a << 8) | 32'h0000_0013;
    endfunction

    function automatic logic [31:0] pc_at(input int i);
        return (i < acc_pc.size()) ? acc_pc[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] instr_at(input int i);
        return (i < acc_instr.size()) ? acc_instr[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic hold_reset(input int l, input logic rdy);
        rst_n          = 1'b0;
        lat            = l;
        id_ready       = rdy;
        gnt_en         = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        tick(2);
    endtask

    task automatic release_reset();
        acc_pc.delete();
        acc_instr.delete();
        rst_n = 1'b1;
    endtask

    // Memory model: in-order responses, plus a log of every entry ID accepts.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq_addr.delete();
            mq_due.delete();
        end else begin
            if (imem_rvalid) begin
                void'(mq_addr.pop_front());
                void'(mq_due.pop_front());
            end
            if (imem_req && imem_gnt) begin
                mq_addr.push_back(imem_addr);
                mq_due.push_back(cyc + lat);
            end
            if (if_valid && id_ready) begin
                acc_pc.push_back(if_pc);
                acc_instr.push_back(if_instr);
            end
            cyc++;
        end
    end

    always @(negedge clk) begin
        if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = instr_of(mq_addr[0]);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end
    end

    initial begin
        rst_n = 1'b1;
        #2;
        @(negedge clk);

        // Reset values, boot cycle and first fetches with a 1-cycle memory.
        hold_reset(1, 1'b1);
        chk("rst_req", imem_req, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_valid", if_valid, 0);
        chk("rst_pc", if_pc, 0);
        chk("rst_pc4", if_pc_plus4, 0);
        chk("rst_instr", if_instr, 0);
`ifdef IF_MISALIGN_CHK_EN
        chk("rst_misal", fetch_misaligned, 0);
`endif
        release_reset();
        chk("boot_req", imem_req, 0);
        tick(1);
        chk("c0_req", imem_req, 1);
        chk("c0_addr", imem_addr, 32'h0);
        chk("c0_valid", if_valid, 0);
        tick(1);
        chk("c1_addr", imem_addr, 32'h4);
        chk("c1_valid", if_valid, 0);
        tick(1);
        chk("c2_valid", if_valid, 1);
        chk("c2_pc", if_pc, 32'h0);
        chk("c2_pc4", if_pc_plus4, 32'h4);
        chk("c2_instr", if_instr, instr_of(32'h0));
        chk("c2_addr", imem_addr, 32'h8);
        tick(1);
        chk("c3_addr", imem_addr, 32'hC);
        chk("c3_pc", if_pc, 32'h4);

        // ID stalled: FIFO fills, requests stop at FIFO_DEPTH, head holds, then drains in order.
        hold_reset(1, 1'b0);
        release_reset();
        tick(4);
        chk("fill_req_c3", imem_req, 1);
        chk("fill_addr_c3", imem_addr, 32'hC);
        for (int i = 0; i < 8; i++) begin
            tick(1);
            chk("fill_req_off", imem_req, 0);
            chk("fill_valid", if_valid, 1);
            chk("fill_pc_hold", if_pc, 32'h0);
        end
        id_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_pc", if_pc, 32'(4 * i));
            chk("drain_instr", if_instr, instr_of(32'(4 * i)));
            tick(1);
        end

        // Asynchronous reset in the middle of traffic clears outputs at once.
        rst_n = 1'b0;
        #1;
        chk("arst_valid", if_valid, 0);
        chk("arst_req", imem_req, 0);

        // Grant withheld for three cycles: request and address hold, no PC skipped.
        hold_reset(1, 1'b1);
        release_reset();
        tick(3);
        chk("stall_addr_c2", imem_addr, 32'h8);
        gnt_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("stall_req", imem_req, 1);
            chk("stall_addr", imem_addr, 32'h8);
        end
        gnt_en = 1'b1;
        tick(1);
        chk("stall_next_addr", imem_addr, 32'hC);
        tick(6);
        for (int i = 0; i < 4; i++) begin
            chk("stall_acc_pc", pc_at(i), 32'(4 * i));
            chk("stall_acc_instr", instr_at(i), instr_of(32'(4 * i)));
        end

        // Redirect with two requests in flight on a slow memory: both late words dropped.
        hold_reset(3, 1'b1);
        release_reset();
        tick(3);
        chk("redir_outst_block", imem_req, 0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        acc_pc.delete();
        acc_instr.delete();
        tick(1);
        redirect_valid = 1'b0;
        chk("redir_flush", if_valid, 0);
        tick(1);
        chk("redir_req", imem_req, 1);
        chk("redir_addr", imem_addr, 32'h100);
        tick(10);
        chk("redir_acc0", pc_at(0), 32'h100);
        chk("redir_instr0", instr_at(0), instr_of(32'h100));
        chk("redir_acc1", pc_at(1), 32'h104);

        // Redirect in the same cycle as a response and an ID acceptance.
        hold_reset(1, 1'b1);
        release_reset();
        tick(3);
        acc_pc.delete();
        acc_instr.delete();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        tick(1);
        redirect_valid = 1'b0;
        chk("same_valid_n1", if_valid, 0);
        chk("same_addr_n1", imem_addr, 32'h300);
        tick(1);
        chk("same_valid_n2", if_valid, 0);
        tick(1);
        chk("same_valid_n3", if_valid, 1);
        chk("same_pc_n3", if_pc, 32'h300);
        chk("same_pc4_n3", if_pc_plus4, 32'h304);
        tick(3);
        chk("same_acc0", pc_at(0), 32'h0);
        chk("same_acc1", pc_at(1), 32'h300);
        chk("same_acc2", pc_at(2), 32'h304);

        // Fetch PC wraps modulo 2^32.
        hold_reset(1, 1'b1);
        release_reset();
        tick(3);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick(1);
        redirect_valid = 1'b0;
        chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        tick(1);
        chk("wrap_addr1", imem_addr, 32'h0);
        tick(1);
        chk("wrap_pc", if_pc, 32'hFFFF_FFFC);
        chk("wrap_pc4", if_pc_plus4, 32'h0);
        chk("wrap_instr", if_instr, instr_of(32'hFFFF_FFFC));
        tick(1);
        chk("wrap_pc_next", if_pc, 32'h0);

        // Misaligned redirect target.
        hold_reset(1, 1'b1);
        release_reset();
        tick(3);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        tick(1);
        redirect_valid = 1'b0;
`ifdef IF_MISALIGN_CHK_EN
        chk("misal_flag", fetch_misaligned, 1);
        chk("misal_req", imem_req, 0);
        tick(2);
        chk("misal_req_hold", imem_req, 0);
        chk("misal_valid", if_valid, 0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        tick(1);
        redirect_valid = 1'b0;
        chk("misal_clear", fetch_misaligned, 0);
        chk("misal_req_back", imem_req, 1);
        chk("misal_addr", imem_addr, 32'h200);
        tick(2);
        chk("misal_pc", if_pc, 32'h200);
`else
        chk("align_req", imem_req, 1);
        chk("align_addr", imem_addr, 32'h100);
        tick(2);
        chk("align_pc", if_pc, 32'h100);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
IF-stage producer of the instruction stream that the ID-stage control decode consumes. The block holds the fetch PC and issues pipelined requests to instruction memory. It buffers returned words in a prefetch FIFO and presents {instr, pc, pc+4} to ID over a valid/ready handshake. Redirects from EX (taken branch, JAL, JALR) flush the FIFO and discard in-flight responses.

Parameters:
XLEN, 32, address/data width
RESET_PC, 32'h0000_0000, first fetch address after reset
FIFO_DEPTH, 4, prefetch entries (power of 2, >=2)
MAX_OUTST, 2, max granted-but-unreturned imem requests (1..FIFO_DEPTH)

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous assert, active-low
redirect_valid  in  1  EX redirect strobe
redirect_pc  in  XLEN  redirect target
imem_req  out  1  request valid
imem_addr  out  XLEN  request word address
imem_gnt  in  1  request accepted this cycle
imem_rvalid  in  1  in-order response valid
imem_rdata  in  XLEN  response instruction
if_valid  out  1  entry available to ID
if_instr  out  XLEN  instruction; bits [6:0] drive the ID opcode
if_pc  out  XLEN  PC of if_instr
if_pc_plus4  out  XLEN  if_pc+4, for JAL/JALR link writeback
id_ready  in  1  ID accepts the entry when if_valid&&id_ready
fetch_misaligned  out  1  present only with IF_MISALIGN_CHK_EN

Behaviour:
- Reset: all outputs 0, fetch_pc=RESET_PC, FIFO empty, outst=0, discard=0, FSM=BOOT.
- FSM BOOT->RUN unconditionally one cycle after rst_n deasserts. No request is issued in BOOT.
- Request rule in RUN: imem_req=1 iff (fifo_count+outst)<FIFO_DEPTH and outst<MAX_OUTST. imem_addr=fetch_pc.
- Handshake: once imem_req is high, the block holds req and addr stable until imem_gnt, except on redirect.
- On gnt: fetch_pc+=4 (wraps mod 2^XLEN), outst+=1.
- Response: imem_rvalid decrements outst. If discard>0, the word is dropped and discard-=1. Otherwise it is pushed with its pc; the pc queue tracks fetch order.
- The FIFO can never overflow, because of the request rule. A push and a pop in the same cycle are legal at any count.
- Output is registered from the FIFO head. A response at cycle M is visible at if_valid in M+1 at the earliest. Redirect to the first if_valid takes at least 3 cycles with single-cycle memory.
- if_valid, if_instr and if_pc hold stable until the entry is accepted.
- Redirect at cycle N:
  - FIFO flushed and if_valid=0 at N+1.
  - fetch_pc=redirect_pc.
  - discard=outst+(gnt@N)-(rvalid@N).
  - A pending ungranted req may be withdrawn or re-addressed.
  - An ID acceptance at N completes normally.
  - rvalid@N is dropped.
  - Fetching at redirect_pc may start at N+1, while discards drain.
- Simultaneous gnt and rvalid: outst unchanged.
- Reset mid-operation: immediate clear. The memory is reset by the same rst_n.

Optional Feature:
IF_MISALIGN_CHK_EN
- Defined:
  - A redirect with redirect_pc[1:0]!=0 moves the FSM to TRAP and sets fetch_misaligned=1.
  - TRAP issues no requests and continues to drain discards.
  - The next aligned redirect clears the flag and returns the FSM to RUN.
- Undefined: the port is absent, there is no TRAP state, and imem_addr[1:0] is forced to 0.

Decomposition:
- Package if_pkg holds:
  - XLEN and RESET_PC defaults
  - fetch_state_t enum {BOOT, RUN, TRAP}
  - if_entry_t struct {instr, pc}
- Sub-module if_fifo: synchronous FIFO with push, pop, flush and count. It stores if_entry_t with parameterised depth and is reusable by the ID skid buffer.

Test Plan:
- Reset release with 1-cycle gnt/rvalid memory and id_ready=1 -> imem_addr sequence 0,4,8,C. First if_valid 3 cycles after rst_n rise with if_pc=0, if_pc_plus4=4.
- id_ready=0 for 10 cycles -> FIFO fills to 4. imem_req drops once count+outst=4. if_pc stays 0 and stable. On release, entries drain in order 0,4,8,C.
- gnt withheld 3 cycles -> imem_req and imem_addr=8 held stable. No pc skip after gnt.
- redirect_pc=0x100 with 2 outstanding, responses 2 cycles late -> both responses dropped. Next if_pc=0x100. No stale instr reaches ID.
- Redirect same cycle as rvalid and ID acceptance -> accepted entry counted once, rvalid word dropped, if_valid=0 next cycle.
- With IF_MISALIGN_CHK_EN, redirect_pc=0x102 -> fetch_misaligned=1 and no imem_req. Redirect to 0x200 clears it and fetches 0x200.
